// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Holds the PC, fetches words over imem req/ack, presents them to decode.
// Latency: memory latency + 1 register stage; at least 2 cycles per instruction (FETCH then ISSUE).
// Backpressure: id_ready low holds the registered word in ISSUE; optional counter under macro IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {FETCH, ISSUE, DRAIN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend, pend_nxt;
  logic [31:0] tgt;
  logic        capture, drop_valid, set_halt;

  // Word-align the redirect target; the low two bits carry no meaning.
  assign tgt = redirect_target & 32'hFFFF_FFFC;

  // A request stays up (address stable) until the memory acks it, even if a
  // redirect arrives meanwhile: DRAIN lets the in-flight fetch complete.
  assign imem_req  = !rst && ((state == FETCH) || (state == DRAIN));
  assign imem_addr = pc;

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      pend  <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
    end
  end

  // Next-state, next-PC and datapath control decode.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    pend_nxt   = pend;
    capture    = 1'b0;
    drop_valid = 1'b0;
    set_halt   = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_nxt = tgt;               // returned word is on the wrong path
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 32'd4;     // wraps mod 2^32
            state_nxt = ISSUE;
          end
        end else if (redirect_valid) begin
          pend_nxt  = tgt;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pend_nxt = tgt;               // latest redirect wins
        end
        if (imem_ack) begin
          pc_nxt    = redirect_valid ? tgt : pend;
          state_nxt = FETCH;
        end
      end
      ISSUE: begin
        if (redirect_valid) begin
          drop_valid = 1'b1;
          pc_nxt     = tgt;
          state_nxt  = FETCH;
        end else if (id_ready) begin
          drop_valid = 1'b1;
          if (instruction[31:26] == HALT_OPCODE) begin
            set_halt  = 1'b1;
            state_nxt = HALTED;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Output registers toward decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= 32'h0;
      pc_plus4    <= 32'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (capture) begin
        instruction <= imem_rdata;
        pc_plus4    <= pc + 32'd4;
        instr_valid <= 1'b1;
      end else if (drop_valid) begin
        instr_valid <= 1'b0;
      end
      if (set_halt) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count accepted handshakes; a redirect in the same cycle cancels the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0;
    end else if (instr_valid && id_ready && !redirect_valid) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Drives inputs and samples outputs 1 time unit after the falling edge.
// A second instance with RESET_PC = 0xFFFF_FFFC covers PC wrap.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc4_2;
  logic        valid2;
  logic        halted2;

  int checks;
  int errors;

  logic [31:0] mem [0:31];
  logic [3:0]  wait_states;
  logic [3:0]  wcnt;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .id_ready(id_ready),
    .instruction(instruction), .pc_plus4(pc_plus4), .instr_valid(instr_valid), .halted(halted)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_target(32'h0), .id_ready(1'b1),
    .instruction(instr2), .pc_plus4(pc4_2), .instr_valid(valid2), .halted(halted2)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_states extra cycles of held request; tolerates dropped requests.
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 4'd0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
  end
  assign imem_ack   = imem_req && (wcnt == wait_states);
  assign imem_rdata = mem[imem_addr[6:2]];

  // Zero-wait memory for the wrap instance, constant non-HALT word.
  assign ack2   = req2;
  assign rdata2 = 32'h2001_0005;

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0; id_ready = 1'b0; wait_states = 4'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    checks++;
    if ({instr_valid, halted, instruction, pc_plus4} !== 66'h0) begin
      errors++;
      $display("FAIL reset_outs got v=%b h=%b i=%h p=%h exp all 0", instr_valid, halted, instruction, pc_plus4);
    end
  endtask

  task automatic test_fetch_halt();
    logic [31:0] exp_instr [0:2];
    logic        req_seen;
    exp_instr[0] = 32'h2001_0005; exp_instr[1] = 32'h2002_0003; exp_instr[2] = 32'hFC00_0000;
    for (int i = 0; i < 3; i++) mem[i] = exp_instr[i];
    wait_states = 4'd0;
    id_ready = 1'b1;
    release_rst();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        errors++; $display("FAIL fh_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 4 * i);
      end
      @(negedge clk); #1;
      checks++;
      if ({instr_valid, instruction, pc_plus4, imem_req} !== {1'b1, exp_instr[i], 32'(4 * i + 4), 1'b0}) begin
        errors++;
        $display("FAIL fh_issue%0d got v=%b i=%h p=%h req=%b exp v=1 i=%h p=%h req=0",
                 i, instr_valid, instruction, pc_plus4, imem_req, exp_instr[i], 4 * i + 4);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({halted, instr_valid} !== 2'b10) begin
      errors++; $display("FAIL fh_halted got h=%b v=%b exp h=1 v=0", halted, instr_valid);
    end
    req_seen = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      redirect_valid = 1'b0;
      req_seen = req_seen | imem_req;
    end
    checks++;
    if ({req_seen, halted} !== 2'b01) begin
      errors++; $display("FAIL fh_frozen got req_seen=%b h=%b exp req_seen=0 h=1", req_seen, halted);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd3) begin errors++; $display("FAIL fh_count got %0d exp 3", fetch_count); end
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({halted, imem_req} !== 2'b00) begin
      errors++; $display("FAIL fh_async_rst got h=%b req=%b exp 0 0", halted, imem_req);
    end
  endtask

  task automatic test_stall_latency();
    wait_states = 4'd2;
    id_ready = 1'b0;
    release_rst();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
        errors++; $display("FAIL st_wait%0d got req=%b addr=%h v=%b exp 1 0 0", k, imem_req, imem_addr, instr_valid);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_valid, instruction, pc_plus4, imem_req} !== {1'b1, 32'h2001_0005, 32'h4, 1'b0}) begin
        errors++;
        $display("FAIL st_hold%0d got v=%b i=%h p=%h req=%b exp 1 20010005 4 0", k, instr_valid, instruction, pc_plus4, imem_req);
      end
    end
    id_ready = 1'b1;
    @(negedge clk); #1;
    id_ready = 1'b0;
    checks++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
      errors++; $display("FAIL st_next got req=%b addr=%h v=%b exp 1 4 0", imem_req, imem_addr, instr_valid);
    end
    rst = 1'b1;
  endtask

  task automatic test_redirect_drain();
    logic v_seen;
    int   n;
    mem[16] = 32'h2003_0001;
    wait_states = 4'd2;
    id_ready = 1'b1;
    release_rst();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rd_drain_addr got req=%b addr=%h exp 1 0", imem_req, imem_addr);
    end
    v_seen = instr_valid;
    @(negedge clk); #1;
    v_seen = v_seen | instr_valid;
    checks++;
    if ({imem_ack, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rd_drain_ack got ack=%b addr=%h exp 1 0", imem_ack, imem_addr);
    end
    @(negedge clk); #1;
    v_seen = v_seen | instr_valid;
    checks++;
    if ({imem_req, imem_addr, v_seen} !== {1'b1, 32'h40, 1'b0}) begin
      errors++; $display("FAIL rd_new_addr got req=%b addr=%h v_seen=%b exp 1 40 0", imem_req, imem_addr, v_seen);
    end
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if ({instr_valid, instruction, pc_plus4} !== {1'b1, 32'h2003_0001, 32'h44}) begin
      errors++;
      $display("FAIL rd_target_word got v=%b i=%h p=%h exp 1 20030001 44", instr_valid, instruction, pc_plus4);
    end
  endtask

  task automatic test_redirect_issue();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
      errors++; $display("FAIL ri_redirect got v=%b req=%b addr=%h exp 0 1 10", instr_valid, imem_req, imem_addr);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL ri_count got %0d exp 0", fetch_count); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_wrap_reset();
    int n;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    checks++;
    if ({req2, addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wr_addr got req=%b addr=%h exp 1 fffffffc", req2, addr2);
    end
    @(negedge clk); #1;
    checks++;
    if ({valid2, pc4_2} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_pc4 got v=%b p=%h exp 1 0", valid2, pc4_2);
    end
    @(negedge clk); #1;
    checks++;
    if ({req2, addr2} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_next got req=%b addr=%h exp 1 0", req2, addr2);
    end
    rst2 = 1'b1;

    // Reset while a redirect is draining an outstanding fetch.
    mem[0] = 32'h2001_0005;
    wait_states = 4'd2;
    id_ready = 1'b1;
    release_rst();
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0080;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req, imem_addr, instruction, pc_plus4} !== {1'b1, 32'h4, 32'h2001_0005, 32'h4}) begin
      errors++;
      $display("FAIL wr_pre_drain got req=%b addr=%h i=%h p=%h exp 1 4 20010005 4", imem_req, imem_addr, instruction, pc_plus4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, instr_valid, halted, instruction, pc_plus4} !== 99'h0) begin
      errors++;
      $display("FAIL wr_async_rst got req=%b addr=%h v=%b h=%b i=%h p=%h exp all 0",
               imem_req, imem_addr, instr_valid, halted, instruction, pc_plus4);
    end
    release_rst();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_restart got req=%b addr=%h exp 1 0", imem_req, imem_addr);
    end
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if ({instr_valid, instruction, pc_plus4} !== {1'b1, 32'h2001_0005, 32'h4}) begin
      errors++; $display("FAIL wr_restart_word got v=%b i=%h p=%h exp 1 20010005 4", instr_valid, instruction, pc_plus4);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_halt();
    test_stall_latency();
    test_redirect_drain();
    test_redirect_issue();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
